tt_sweep_ctrl: RTL and testbench
================================

# tt_sweep_ctrl

Sequencer that exhaustively exercises a 4-input, 2-output combinational block (inputs a,b,c,d; outputs f1,f2) in hardware instead of from a testbench. On `start` it drives all 16 input vectors in ascending order, holds each for a programmable settle time, samples both outputs, and builds two 16-bit captured truth tables. It then compares them against latched expected tables and reports pass/fail. It sits between a lab top-level (switches/LEDs or a self-checking bench) and the unmodified combinational DUT.

## Interface
- `HOLD_CYCLES`, default 2: cycles a vector is driven before its sample cycle (legal range 1..15).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: level, accepted only in IDLE.
- `abort` in 1: synchronous cancel, effective in any busy state.
- `expect_f1` in 16: expected f1 table; bit i = vector i. Latched on start accept.
- `expect_f2` in 16: expected f2 table, same encoding.
- `f1`, `f2` in 1 each: DUT outputs.
- `abcd` out 4: vector to DUT. `abcd[3]`=a … `abcd[0]`=d, so vector i = {a,b,c,d}.
- `busy` out 1: high in DRIVE/SAMPLE.
- `done` out 1: one-cycle pulse on sweep completion.
- `result_f1`, `result_f2` out 16: captured tables.
- `mismatch` out 16: bit i = (result_f1[i]^exp_f1[i]) | (result_f2[i]^exp_f2[i]).
- `pass` out 1: valid from the done pulse until the next start; high iff mismatch==0.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE: abcd=0, busy=0. `start`=1 → latch expects, clear results/mismatch/pass, idx=0, hold counter=HOLD_CYCLES-1 → DRIVE.
- DRIVE: abcd=idx. Counter decrements each cycle; at 0 → SAMPLE.
- SAMPLE: abcd=idx. At the closing edge: write f1/f2 into result bit idx; compute mismatch bit idx. If idx==15 → DONE, else idx+1, reload counter → DRIVE.
- DONE: done=1 for exactly one cycle; pass = (mismatch==0); → IDLE.
- Results, mismatch and pass hold after DONE until the next accepted start.
- `start` while busy or in DONE: ignored. Expects changing while busy: no effect (latched copy used).
- `abort`=1 in DRIVE/SAMPLE: → IDLE next edge; no done pulse; pass=0; partial results retained. Abort has priority over a sample in the same cycle (no capture). Abort in IDLE/DONE: no effect.
- idx is 4 bits; no wrap occurs because DONE is taken at 15.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, abcd=0, busy=0, done=0, pass=0, result_f1=result_f2=mismatch=0, idx=0.
- Start accepted at edge E0. abcd=0 is valid from E0. Each vector is driven HOLD_CYCLES+1 cycles and sampled on its last edge.
- Last sample at edge E0+16·(HOLD_CYCLES+1). `done`/`pass` are high in the following cycle. Default: done high 48 cycles after E0.
- busy rises the cycle after E0 and falls when DONE is entered.
- DUT output path must settle within HOLD_CYCLES+1 clock periods.
- Reset mid-sweep: immediate return to the reset values above.

## Structure
- Package `tt_sweep_pkg` holds:
  - state enum (IDLE, DRIVE, SAMPLE, DONE);
  - `NUM_VEC`=16, `IDX_W`=4, `OUT_W`=2;
  - a function mapping idx to {a,b,c,d}.
- Sub-module `tt_hold_timer`: loadable down-counter with `load`, `value` and `zero` outputs, width clog2(16).
- Datapath (result/mismatch shift-in by index) and FSM live in the top module. The DUT is instantiated outside the block.

## Test plan
- Bench DUT model f1=a&b, f2=c|d; expects 16'hF000 / 16'hEEEE; HOLD=2.
  - Required: abcd steps 0..15, each held 3 cycles.
  - Required: result_f1=F000, result_f2=EEEE, mismatch=0, pass=1, done exactly 48 cycles after start.
- Same DUT with expect_f2=16'hEEEF.
  - Required: mismatch=16'h0001, pass=0, done still pulses once.
- Abort asserted during vector 7's SAMPLE cycle.
  - Required: IDLE next cycle, no done, pass=0, result bits 0..6 captured and bit 7 not written.
- start held high continuously through a sweep and toggled mid-sweep.
  - Required: exactly one sweep; re-accepted only after DONE→IDLE, and results then clear.
- rst_n pulsed low asynchronously mid-DRIVE (vector 9).
  - Required: all outputs go to reset values without a clock edge; a subsequent start sweeps from vector 0.
- HOLD_CYCLES=1 instance.
  - Required: each vector held 2 cycles; done 32 cycles after start.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
`default_nettype none
// ============================================================
// tt_sweep_pkg : shared types and constants for the truth-table sweeper
// Rev 1.0
// ============================================================
package tt_sweep_pkg;

   localparam int NUM_VEC = 16;
   localparam int IDX_W   = 4;
   localparam int OUT_W   = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   // Vector i is presented as {a,b,c,d}, so the index maps straight through.
   function automatic logic [3:0] idx_to_abcd(input logic [IDX_W-1:0] idx);
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tt_sweep_ctrl_if.sv
`default_nettype none
// ============================================================
// tt_sweep_ctrl_if : control/result bundle plus DUT vector/response pins
// Rev 1.0
// ============================================================
interface tt_sweep_ctrl_if;
   import tt_sweep_pkg::*;

   logic               start;
   logic               abort;
   logic [NUM_VEC-1:0] expect_f1;
   logic [NUM_VEC-1:0] expect_f2;
   logic               f1;
   logic               f2;
   logic [IDX_W-1:0]   abcd;
   logic               busy;
   logic               done;
   logic [NUM_VEC-1:0] result_f1;
   logic [NUM_VEC-1:0] result_f2;
   logic [NUM_VEC-1:0] mismatch;
   logic               pass;

   modport slave (
      input  start, abort, expect_f1, expect_f2, f1, f2,
      output abcd, busy, done, result_f1, result_f2, mismatch, pass
   );

   modport master (
      output start, abort, expect_f1, expect_f2, f1, f2,
      input  abcd, busy, done, result_f1, result_f2, mismatch, pass
   );

endinterface
`default_nettype wire

// File: rtl/tt_hold_timer.sv
`default_nettype none
// ============================================================
// tt_hold_timer : loadable down-counter timing each vector's settle window
// Rev 1.0
// ============================================================
module tt_hold_timer #(
   parameter int WIDTH = 4
) (
   input  wire              clk,
   input  wire              rst_n,
   input  wire              load,
   input  wire              en,
   input  wire  [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] value,
   output logic             zero
);

   logic [WIDTH-1:0] value_q;
   logic [WIDTH-1:0] value_d;

   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_value;
      end else if (en) begin
         value_d = value_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;
   assign zero  = (value_q == '0);

endmodule
`default_nettype wire

// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// ============================================================
// tt_sweep_ctrl : drives all 16 input vectors, captures f1/f2 truth tables, grades them
// Rev 1.0
// ============================================================
module tt_sweep_ctrl #(
   parameter int HOLD_CYCLES = 2
) (
   input wire             clk,
   input wire             rst_n,
   tt_sweep_ctrl_if.slave sw
);
   import tt_sweep_pkg::*;

   localparam int               TMR_W    = $clog2(NUM_VEC);
   localparam logic [TMR_W-1:0] c_reload = TMR_W'(HOLD_CYCLES - 1);

   state_e             state_q,  state_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic [NUM_VEC-1:0] exp_f1_q, exp_f1_d;
   logic [NUM_VEC-1:0] exp_f2_q, exp_f2_d;
   logic [NUM_VEC-1:0] res_f1_q, res_f1_d;
   logic [NUM_VEC-1:0] res_f2_q, res_f2_d;
   logic [NUM_VEC-1:0] mism_q,   mism_d;
   logic               pass_q,   pass_d;

   logic               timer_load;
   logic               timer_en;
   logic [TMR_W-1:0]   timer_value;
   logic               timer_zero;

   tt_hold_timer #(.WIDTH(TMR_W)) u_hold_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (timer_load),
      .en         (timer_en),
      .load_value (c_reload),
      .value      (timer_value),
      .zero       (timer_zero)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      exp_f1_d   = exp_f1_q;
      exp_f2_d   = exp_f2_q;
      res_f1_d   = res_f1_q;
      res_f2_d   = res_f2_q;
      mism_d     = mism_q;
      pass_d     = pass_q;
      timer_load = 1'b0;
      timer_en   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sw.start) begin
               exp_f1_d   = sw.expect_f1;
               exp_f2_d   = sw.expect_f2;
               res_f1_d   = '0;
               res_f2_d   = '0;
               mism_d     = '0;
               pass_d     = 1'b0;
               idx_d      = '0;
               timer_load = 1'b1;
               state_d    = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (sw.abort) begin
               pass_d  = 1'b0;
               idx_d   = '0;
               state_d = ST_IDLE;
            end else if (timer_zero) begin
               state_d = ST_SAMPLE;
            end else begin
               timer_en = (timer_value != '0);
            end
         end
         ST_SAMPLE: begin
            // Abort wins over the capture scheduled for this edge.
            if (sw.abort) begin
               pass_d  = 1'b0;
               idx_d   = '0;
               state_d = ST_IDLE;
            end else begin
               res_f1_d[idx_q] = sw.f1;
               res_f2_d[idx_q] = sw.f2;
               mism_d[idx_q]   = (sw.f1 ^ exp_f1_q[idx_q]) | (sw.f2 ^ exp_f2_q[idx_q]);
               if (idx_q == IDX_W'(NUM_VEC - 1)) begin
                  pass_d  = (mism_d == '0);
                  state_d = ST_DONE;
               end else begin
                  idx_d      = idx_q + IDX_W'(1);
                  timer_load = 1'b1;
                  state_d    = ST_DRIVE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         exp_f1_q <= '0;
         exp_f2_q <= '0;
         res_f1_q <= '0;
         res_f2_q <= '0;
         mism_q   <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         exp_f1_q <= exp_f1_d;
         exp_f2_q <= exp_f2_d;
         res_f1_q <= res_f1_d;
         res_f2_q <= res_f2_d;
         mism_q   <= mism_d;
         pass_q   <= pass_d;
      end
   end

   assign sw.busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
   assign sw.done      = (state_q == ST_DONE);
   assign sw.abcd      = sw.busy ? idx_to_abcd(idx_q) : '0;
   assign sw.result_f1 = res_f1_q;
   assign sw.result_f2 = res_f2_q;
   assign sw.mismatch  = mism_q;
   assign sw.pass      = pass_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_ctrl.sv
`default_nettype none
// ============================================================
// tb_tt_sweep_ctrl : scoreboard bench for the sweeper, HOLD=2 and HOLD=1 instances
// Rev 1.0
// ============================================================
module tb_tt_sweep_ctrl;
   import tt_sweep_pkg::*;

   typedef struct {
      logic [15:0] r1;
      logic [15:0] r2;
      logic [15:0] mm;
      logic        pass;
      int          done_cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;

   tt_sweep_ctrl_if if_a ();
   tt_sweep_ctrl_if if_b ();

   tt_sweep_ctrl #(.HOLD_CYCLES(2)) u_dut_a (.clk(clk), .rst_n(rst_n), .sw(if_a));
   tt_sweep_ctrl #(.HOLD_CYCLES(1)) u_dut_b (.clk(clk), .rst_n(rst_n), .sw(if_b));

   // Combinational block under test: an arbitrary truth table per output.
   logic [15:0] tbl1_a = 16'h0, tbl2_a = 16'h0, tbl1_b = 16'h0, tbl2_b = 16'h0;
   assign if_a.f1 = tbl1_a[if_a.abcd];
   assign if_a.f2 = tbl2_a[if_a.abcd];
   assign if_b.f1 = tbl1_b[if_b.abcd];
   assign if_b.f2 = tbl2_b[if_b.abcd];

   exp_t sb_a[$];
   exp_t sb_b[$];
   bit   act_a = 1'b0, act_b = 1'b0;
   int   s_a = 0, s_b = 0;

   logic [15:0] rt1, rt2, re1, re2;
   logic [3:0]  v_ab;
   logic        v_bu, v_dn, v_ps;
   logic [15:0] v_r1, v_r2, v_mm;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Expected behaviour of cycle k after the accepting edge, from the timing rules.
   task automatic check_cycle(input string tag, input int h, input int k,
                              input logic [3:0] abcd, input logic busy, input logic done);
      int lim;
      lim = 16 * (h + 1);
      if (k >= 0 && k < lim) begin
         check({tag, "_abcd"}, 32'(abcd), 32'(k / (h + 1)));
         check({tag, "_busy"}, 32'(busy), 32'(1));
         check({tag, "_done_early"}, 32'(done), 32'(0));
      end else if (k == lim) begin
         check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
         check({tag, "_done_pulse"}, 32'(done), 32'(1));
      end else if (k == lim + 1) begin
         check({tag, "_busy_after"}, 32'(busy), 32'(0));
         check({tag, "_done_width"}, 32'(done), 32'(0));
      end
   endtask

   task automatic check_result(input string tag, input exp_t e, input logic [15:0] r1,
                               input logic [15:0] r2, input logic [15:0] mm, input logic ps);
      check({tag, "_done_cycle"}, 32'(cyc), 32'(e.done_cyc));
      check({tag, "_result_f1"}, 32'(r1), 32'(e.r1));
      check({tag, "_result_f2"}, 32'(r2), 32'(e.r2));
      check({tag, "_mismatch"}, 32'(mm), 32'(e.mm));
      check({tag, "_pass"}, 32'(ps), 32'(e.pass));
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst_n) begin
         if (act_a) check_cycle("a", 2, cyc - s_a, if_a.abcd, if_a.busy, if_a.done);
         if (if_a.done) begin
            if (sb_a.size() == 0) check("a_spurious_done", 32'(1), 32'(0));
            else begin
               e = sb_a.pop_front();
               check_result("a", e, if_a.result_f1, if_a.result_f2, if_a.mismatch, if_a.pass);
            end
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (rst_n) begin
         if (act_b) check_cycle("b", 1, cyc - s_b, if_b.abcd, if_b.busy, if_b.done);
         if (if_b.done) begin
            if (sb_b.size() == 0) check("b_spurious_done", 32'(1), 32'(0));
            else begin
               e = sb_b.pop_front();
               check_result("b", e, if_b.result_f1, if_b.result_f2, if_b.mismatch, if_b.pass);
            end
         end
      end
   end

   task automatic snap(input bit b, output logic [3:0] ab, output logic bu, output logic dn,
                       output logic ps, output logic [15:0] r1, output logic [15:0] r2,
                       output logic [15:0] mm);
      if (b) begin
         ab = if_b.abcd; bu = if_b.busy; dn = if_b.done; ps = if_b.pass;
         r1 = if_b.result_f1; r2 = if_b.result_f2; mm = if_b.mismatch;
      end else begin
         ab = if_a.abcd; bu = if_a.busy; dn = if_a.done; ps = if_a.pass;
         r1 = if_a.result_f1; r2 = if_a.result_f2; mm = if_a.mismatch;
      end
   endtask

   task automatic check_reset_vals(input bit b, input string tag);
      snap(b, v_ab, v_bu, v_dn, v_ps, v_r1, v_r2, v_mm);
      check({tag, "_abcd"}, 32'(v_ab), 32'(0));
      check({tag, "_busy"}, 32'(v_bu), 32'(0));
      check({tag, "_done"}, 32'(v_dn), 32'(0));
      check({tag, "_pass"}, 32'(v_ps), 32'(0));
      check({tag, "_result_f1"}, 32'(v_r1), 32'(0));
      check({tag, "_result_f2"}, 32'(v_r2), 32'(0));
      check({tag, "_mismatch"}, 32'(v_mm), 32'(0));
   endtask

   task automatic wait_idle(input bit b);
      int t;
      t = 0;
      while (b ? (if_b.busy || if_b.done) : (if_a.busy || if_a.done)) begin
         @(posedge clk); #2;
         t++;
         if (t > 200) begin
            check(b ? "b_idle_timeout" : "a_idle_timeout", 32'(1), 32'(0));
            return;
         end
      end
   endtask

   task automatic wait_done(input bit b);
      int t;
      t = 0;
      while (!(b ? if_b.done : if_a.done)) begin
         @(posedge clk); #2;
         t++;
         if (t > 200) begin
            check(b ? "b_done_timeout" : "a_done_timeout", 32'(1), 32'(0));
            return;
         end
      end
      @(posedge clk); #2;
   endtask

   // Called just after the accepting edge: record the expected sweep outcome.
   task automatic accept(input bit b, input logic [15:0] t1, input logic [15:0] t2,
                         input logic [15:0] e1, input logic [15:0] e2);
      exp_t e;
      int   h;
      h          = b ? 1 : 2;
      e.r1       = t1;
      e.r2       = t2;
      e.mm       = (t1 ^ e1) | (t2 ^ e2);
      e.pass     = (e.mm == 16'h0);
      e.done_cyc = cyc + 16 * (h + 1);
      if (b) begin sb_b.push_back(e); s_b = cyc; act_b = 1'b1; end
      else   begin sb_a.push_back(e); s_a = cyc; act_a = 1'b1; end
   endtask

   task automatic issue(input bit b, input logic [15:0] t1, input logic [15:0] t2,
                        input logic [15:0] e1, input logic [15:0] e2);
      wait_idle(b);
      if (b) begin
         tbl1_b = t1; tbl2_b = t2; if_b.expect_f1 = e1; if_b.expect_f2 = e2; if_b.start = 1'b1;
      end else begin
         tbl1_a = t1; tbl2_a = t2; if_a.expect_f1 = e1; if_a.expect_f2 = e2; if_a.start = 1'b1;
      end
      @(posedge clk); #2;
      accept(b, t1, t2, e1, e2);
   endtask

   // Drop start and churn the expect inputs; the latched copy must be used.
   task automatic scramble(input bit b);
      if (b) begin
         if_b.start = 1'b0; if_b.expect_f1 = 16'($urandom); if_b.expect_f2 = 16'($urandom);
      end else begin
         if_a.start = 1'b0; if_a.expect_f1 = 16'($urandom); if_a.expect_f2 = 16'($urandom);
      end
   endtask

   task automatic run_sweep(input bit b, input logic [15:0] t1, input logic [15:0] t2,
                            input logic [15:0] e1, input logic [15:0] e2);
      issue(b, t1, t2, e1, e2);
      scramble(b);
      wait_done(b);
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      if_a.start = 1'b0; if_a.abort = 1'b0; if_a.expect_f1 = '0; if_a.expect_f2 = '0;
      if_b.start = 1'b0; if_b.abort = 1'b0; if_b.expect_f1 = '0; if_b.expect_f2 = '0;
      repeat (3) @(posedge clk); #2;
      check_reset_vals(1'b0, "a_por");
      check_reset_vals(1'b1, "b_por");
      rst_n = 1'b1;
      @(posedge clk); #2;

      // f1 = a&b, f2 = c|d
      run_sweep(1'b0, 16'hF000, 16'hEEEE, 16'hF000, 16'hEEEE);
      run_sweep(1'b0, 16'hF000, 16'hEEEE, 16'hF000, 16'hEEEF);
      run_sweep(1'b1, 16'hF000, 16'hEEEE, 16'hF000, 16'hEEEE);

      // Abort in vector 7's sample cycle; bit 7 would otherwise set result and mismatch.
      rt1 = 16'($urandom) | 16'h0080;
      rt2 = 16'($urandom) | 16'h0080;
      re1 = rt1 ^ (16'h0080 | (16'($urandom) & 16'h007F));
      re2 = rt2 ^ (16'($urandom) & 16'hFF7F);
      issue(1'b0, rt1, rt2, re1, re2);
      scramble(1'b0);
      repeat (23) @(posedge clk); #2;
      if_a.abort = 1'b1;
      @(posedge clk); #2;
      if_a.abort = 1'b0;
      act_a = 1'b0;
      sb_a.delete();
      snap(1'b0, v_ab, v_bu, v_dn, v_ps, v_r1, v_r2, v_mm);
      check("abort_busy", 32'(v_bu), 32'(0));
      check("abort_abcd", 32'(v_ab), 32'(0));
      check("abort_done", 32'(v_dn), 32'(0));
      check("abort_pass", 32'(v_ps), 32'(0));
      check("abort_result_f1", 32'(v_r1), 32'(rt1 & 16'h007F));
      check("abort_result_f2", 32'(v_r2), 32'(rt2 & 16'h007F));
      check("abort_mismatch", 32'(v_mm), 32'(((rt1 ^ re1) | (rt2 ^ re2)) & 16'h007F));
      if_a.abort = 1'b1;
      repeat (3) begin
         @(posedge clk); #2;
         check("abort_idle_no_done", 32'(if_a.done), 32'(0));
         check("abort_idle_hold_f1", 32'(if_a.result_f1), 32'(rt1 & 16'h007F));
      end
      if_a.abort = 1'b0;

      // start held high through the sweep, toggled mid-sweep, re-accepted after DONE.
      rt1 = 16'($urandom); rt2 = 16'($urandom) | 16'h0001;
      re1 = rt1; re2 = rt2 ^ 16'h8000;
      issue(1'b0, rt1, rt2, re1, re2);
      repeat (10) @(posedge clk); #2;
      if_a.start = 1'b0; @(posedge clk); #2;
      if_a.start = 1'b1; @(posedge clk); #2;
      if_a.start = 1'b0; @(posedge clk); #2;
      if_a.start = 1'b1;
      repeat (36) @(posedge clk); #2;
      check("hold_idle_busy", 32'(if_a.busy), 32'(0));
      check("hold_idle_result_f1", 32'(if_a.result_f1), 32'(rt1));
      check("hold_idle_pass", 32'(if_a.pass), 32'(0));
      if_a.expect_f1 = ~rt1; if_a.expect_f2 = rt2;
      @(posedge clk); #2;
      accept(1'b0, rt1, rt2, ~rt1, rt2);
      check("rearm_busy", 32'(if_a.busy), 32'(1));
      check("rearm_result_f1_clear", 32'(if_a.result_f1), 32'(0));
      check("rearm_result_f2_clear", 32'(if_a.result_f2), 32'(0));
      check("rearm_mismatch_clear", 32'(if_a.mismatch), 32'(0));
      scramble(1'b0);
      wait_done(1'b0);

      // Asynchronous reset pulse during vector 9's drive phase.
      rt1 = 16'($urandom) | 16'h0001; rt2 = 16'($urandom) | 16'h0001;
      issue(1'b0, rt1, rt2, ~rt1, rt2);
      scramble(1'b0);
      repeat (27) @(posedge clk); #3;
      check("pre_reset_abcd", 32'(if_a.abcd), 32'(9));
      rst_n = 1'b0;
      #1;
      act_a = 1'b0;
      sb_a.delete();
      check_reset_vals(1'b0, "a_async_rst");
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      run_sweep(1'b0, rt1, rt2, rt1, rt2);

      for (int i = 0; i < 8; i++) begin
         rt1 = 16'($urandom);
         rt2 = 16'($urandom);
         re1 = rt1 ^ (($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0);
         re2 = rt2 ^ (($urandom_range(0, 2) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0);
         run_sweep((i % 3) == 2, rt1, rt2, re1, re2);
      end

      wait_idle(1'b0);
      wait_idle(1'b1);
      repeat (3) @(posedge clk); #2;
      check("a_scoreboard_drained", 32'(sb_a.size()), 32'(0));
      check("b_scoreboard_drained", 32'(sb_b.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
